// File: rtl/lrot_pipe.sv
// ============================================================================
// Module   : lrot_pipe
// Purpose  : Pipelined left rotator. Each stage handles one shift-amount bit
//            and has a valid/ready handshake. Define LROT_DIR_EN to add in_dir,
//            which selects right rotation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lrot_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
`ifdef LROT_DIR_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [SHW-1:0]             r_valid;
    logic [SHW-1:0][WIDTH-1:0]  r_data;
    logic [SHW-1:0][SHW-1:0]    r_shift;

    logic [SHW-1:0]             w_adv;
    logic [SHW-1:0]             w_src_valid;
    logic [SHW-1:0][WIDTH-1:0]  w_src_data;
    logic [SHW-1:0][WIDTH-1:0]  w_rot;
    logic [SHW-1:0][SHW-1:0]    w_src_shift;
    logic [SHW-1:0]             w_in_shift;
    logic                       w_unused;

`ifdef LROT_DIR_EN
    logic [SHW-1:0]             r_dir;
    logic [SHW-1:0]             w_src_dir;

    // A right rotate by n is a left rotate by (WIDTH - n) mod WIDTH.
    assign w_in_shift = in_dir ? (SHW'(0) - in_shift) : in_shift;
    assign w_unused   = ^{r_shift, w_src_shift, r_dir};
`else
    assign w_in_shift = in_shift;
    assign w_unused   = ^{r_shift, w_src_shift};
`endif

    // A stage may load when it is empty or when everything downstream moves.
    always_comb begin
        w_adv          = '0;
        w_adv[SHW-1]   = !r_valid[SHW-1] | out_ready;
        for (int k = SHW - 2; k >= 0; k--) begin
            w_adv[k] = !r_valid[k] | w_adv[k+1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int R = 1 << k;

        if (k == 0) begin : g_head
            assign w_src_valid[k] = in_valid;
            assign w_src_data[k]  = in_data;
            assign w_src_shift[k] = w_in_shift;
`ifdef LROT_DIR_EN
            assign w_src_dir[k]   = in_dir;
`endif
        end else begin : g_body
            assign w_src_valid[k] = r_valid[k-1];
            assign w_src_data[k]  = r_data[k-1];
            assign w_src_shift[k] = r_shift[k-1];
`ifdef LROT_DIR_EN
            assign w_src_dir[k]   = r_dir[k-1];
`endif
        end

        assign w_rot[k] = w_src_shift[k][k]
                        ? {w_src_data[k][WIDTH-1-R:0], w_src_data[k][WIDTH-1:WIDTH-R]}
                        : w_src_data[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_shift <= '0;
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    r_data[k]  <= w_rot[k];
                    r_shift[k] <= w_src_shift[k];
                end
            end
        end
    end

`ifdef LROT_DIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= '0;
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (w_adv[k]) begin
                    r_dir[k] <= w_src_dir[k];
                end
            end
        end
    end
`endif

    assign in_ready  = w_adv[0];
    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_data[SHW-1];

endmodule

`default_nettype wire

// File: tb/tb_lrot_pipe.sv
// Testbench for lrot_pipe (WIDTH=8, SHW=3): directed vectors, backpressure,
// out_ready toggling and asynchronous reset while words are in flight.
`default_nettype none

module tb_lrot_pipe;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_shift = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef LROT_DIR_EN
    logic             in_dir = 1'b0;
`endif

    lrot_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
`ifdef LROT_DIR_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] expq[$];
    int         checks = 0;
    int         errors = 0;
    int         n_out = 0;
    bit         mon_en = 1'b0;
    bit         tog_en = 1'b0;
    bit         last_acc = 1'b0;

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: observe the handshakes at the falling edge, step past the rising edge.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (mon_en && out_valid && out_ready) begin
            n_out++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %0h expected none", out_data);
            end else begin
                e = expq.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data got %0h expected %0h", out_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
        if (tog_en) out_ready = ~out_ready;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] s, output int tries);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        tries    = 0;
        do begin
            cyc();
            tries++;
        end while (!last_acc && tries < 200);
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 200) begin
            cyc();
            n++;
        end
        chk("drain_pending", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         tries;
        int         lat;
        int         idx;
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] bpd[5];
        logic [2:0] bps[5];

        tbl[0] = '{8'h81, 3'd1, 8'h03};
        tbl[1] = '{8'hA5, 3'd4, 8'h5A};
        tbl[2] = '{8'h01, 3'd7, 8'h80};
        tbl[3] = '{8'hB4, 3'd3, 8'hA5};
        tbl[4] = '{8'h3C, 3'd0, 8'h3C};
        tbl[5] = '{8'h80, 3'd1, 8'h01};
        tbl[6] = '{8'h12, 3'd4, 8'h21};
        tbl[7] = '{8'h5A, 3'd5, 8'h4B};

        bpd = '{8'h11, 8'h80, 8'hF0, 8'h0E, 8'h5A};
        bps = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd5};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Single word latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        in_shift  = 3'd1;
        cyc();
        chk("t1_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_data", 32'(out_data), 32'h03);
        cyc();
        chk("t1_consumed", 32'(out_valid), 32'd0);

        // Back-to-back directed table
        mon_en = 1'b1;
        n_out  = 0;
        foreach (tbl[i]) begin
            expq.push_back(tbl[i].exp);
            send(tbl[i].d, tbl[i].s, tries);
            chk("tbl_in_ready", 32'(tries), 32'd1);
        end
        drain();
        chk("tbl_count", 32'(n_out), 32'd8);

        // Backpressure: fill the pipe, hold the output, then release
        out_ready = 1'b0;
        n_out = 0;
        idx = 0;
        for (int i = 0; i < 5; i++) expq.push_back(rotl(bpd[i], int'(bps[i])));
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = bpd[idx];
            in_shift = bps[idx];
            cyc();
            if (last_acc) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'h22);
        cyc();
        cyc();
        chk("bp_hold", 32'(out_data), 32'h22);
        out_ready = 1'b1;
        for (int i = idx; i < 5; i++) send(bpd[i], bps[i], tries);
        drain();
        chk("bp_count", 32'(n_out), 32'd5);

        // Stream with out_ready toggling every cycle
        tog_en = 1'b1;
        n_out  = 0;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
            expq.push_back(rotl(d, int'(s)));
            send(d, s, tries);
        end
        drain();
        tog_en    = 1'b0;
        out_ready = 1'b1;
        chk("tog_count", 32'(n_out), 32'd16);

        // Asynchronous reset with words in flight
        mon_en    = 1'b0;
        out_ready = 1'b0;
        send(8'h01, 3'd1, tries);
        send(8'h02, 3'd2, tries);
        send(8'h03, 3'd3, tries);
        chk("rst_inflight_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        n_out     = 0;
        for (int i = 0; i < 5; i++) cyc();
        chk("arst_no_stale", 32'(n_out), 32'd0);
        expq.push_back(8'h0F);
        send(8'hC3, 3'd2, tries);
        drain();
        chk("arst_next_count", 32'(n_out), 32'd1);

`ifdef LROT_DIR_EN
        n_out  = 0;
        in_dir = 1'b1;
        expq.push_back(8'hC0);
        send(8'h81, 3'd1, tries);
        in_dir = 1'b1;
        expq.push_back(8'h81);
        send(8'h81, 3'd0, tries);
        in_dir = 1'b0;
        expq.push_back(8'h03);
        send(8'h81, 3'd1, tries);
        drain();
        chk("dir_count", 32'(n_out), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
